// File: rtl/rst_seq.sv
// rst_seq: PLL-lock reset sequencer with staggered per-channel release.
// Optional RST_SEQ_LOCK_FILT_EN: ignore lock drops shorter than 4 cycles in RUN.
module rst_seq #(
    parameter int N_CH        = 4,
    parameter int HOLD_CYC    = 16,
    parameter int STAGGER_CYC = 4,
    parameter int SW_RST_CYC  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pll_locked,
    input  logic            sw_rst,
    output logic [N_CH-1:0] rst_out,
    output logic            ready,
    output logic            lock_lost
);

    localparam int MAX_HS = (HOLD_CYC > STAGGER_CYC) ? HOLD_CYC : STAGGER_CYC;
    localparam int MAXC   = (MAX_HS > SW_RST_CYC) ? MAX_HS : SW_RST_CYC;
    localparam int CW     = $clog2(MAXC) + 1;
    localparam int IW     = $clog2(N_CH) + 1;

    localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] STAG_END = CW'(STAGGER_CYC - 1);
    localparam logic [CW-1:0] SW_END   = CW'(SW_RST_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_CH - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        HOLD,
        RELEASE,
        RUN,
        SWRST
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [1:0]      sync_q;
    logic [N_CH-1:0] rst_out_q, rst_out_d;
    logic            ready_q, ready_d;
    logic            lost_q, lost_d;
    logic            lk_s;
    logic            lose_run;

    assign lk_s = sync_q[1];

`ifdef RST_SEQ_LOCK_FILT_EN
    logic [1:0] zcnt_q, zcnt_d;

    // Consecutive low samples of lk_s seen while in RUN, saturating at 3.
    always_comb begin
        zcnt_d = '0;
        if (state_q == RUN && !lk_s)
            zcnt_d = (zcnt_q == 2'd3) ? zcnt_q : zcnt_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) zcnt_q <= '0;
        else        zcnt_q <= zcnt_d;
    end

    assign lose_run = !lk_s && (zcnt_q == 2'd3);
`else
    assign lose_run = !lk_s;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            idx_q     <= '0;
            sync_q    <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sync_q    <= {sync_q[0], pll_locked};
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            lost_q    <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (sw_rst && state_q != SWRST) begin
            state_d = SWRST;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    cnt_d = '0;
                    if (lk_s) state_d = HOLD;
                end
                HOLD: begin
                    if (!lk_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == HOLD_END) begin
                        state_d = (N_CH == 1) ? RUN : RELEASE;
                        cnt_d   = '0;
                        idx_d   = IW'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RELEASE: begin
                    if (!lk_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STAG_END) begin
                        cnt_d = '0;
                        idx_d = idx_q + IW'(1);
                        if (idx_q == IDX_LAST) state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RUN: begin
                    if (lose_run) state_d = WAIT_LOCK;
                end
                SWRST: begin
                    if (cnt_q != SW_END) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (!sw_rst) begin
                        state_d = lk_s ? HOLD : WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Channels below idx are released; releases stay monotone by construction.
    always_comb begin
        rst_out_d = '1;
        for (int i = 0; i < N_CH; i++) begin
            if (state_d == RUN)
                rst_out_d[i] = 1'b0;
            else if (state_d == RELEASE && i < int'(idx_d))
                rst_out_d[i] = 1'b0;
        end
        ready_d = (state_d == RUN);
        lost_d  = lost_q | (state_q == RUN && state_d == WAIT_LOCK);
    end

    assign rst_out   = rst_out_q;
    assign ready     = ready_q;
    assign lock_lost = lost_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: randomized scoreboard bench for rst_seq (default and N_CH=1 builds).
// Reference model tracks time since sequencing start rather than FSM states.
module tb_rst_seq;

    localparam int N0 = 4, H0 = 16, S0 = 4, W0 = 8;
    localparam int N1 = 1, H1 = 16, S1 = 1, W1 = 8;
`ifdef RST_SEQ_LOCK_FILT_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic clk = 1'b1;
    logic rst_n = 1'b0;
    logic pll_locked = 1'b0;
    logic sw_rst = 1'b0;
    logic [N0-1:0] ro0;
    logic [N1-1:0] ro1;
    logic rdy0, rdy1, ll0, ll1;

    always #5 clk = ~clk;

    rst_seq #(.N_CH(N0), .HOLD_CYC(H0), .STAGGER_CYC(S0), .SW_RST_CYC(W0)) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .sw_rst(sw_rst),
        .rst_out(ro0), .ready(rdy0), .lock_lost(ll0)
    );

    rst_seq #(.N_CH(N1), .HOLD_CYC(H1), .STAGGER_CYC(S1), .SW_RST_CYC(W1)) dut1 (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .sw_rst(sw_rst),
        .rst_out(ro1), .ready(rdy1), .lock_lost(ll1)
    );

    // mode: 0 waiting for lock, 1 sequencing (t edges since start), 2 sw reset
    typedef struct packed {
        bit s1;
        bit s2;
        int mode;
        int t;
        int s;
        int z;
        bit lost;
    } mdl_t;

    typedef struct packed {
        logic [N0-1:0] ro0;
        logic          rdy0;
        logic          ll0;
        logic [N1-1:0] ro1;
        logic          rdy1;
        logic          ll1;
    } exp_t;

    exp_t q[$];
    mdl_t m0, m1;
    int ntests = 0;
    int nfail = 0;
    int cyc = 0;
    bit armed = 1'b0;

    function automatic mdl_t step(mdl_t m, bit rn, bit pll, bit sw,
                                  int n, int h, int st, int swc);
        mdl_t r;
        bit lk, run, drop;
        r = m;
        if (!rn) begin
            r = '0;
            return r;
        end
        lk = m.s2;
        r.s2 = m.s1;
        r.s1 = pll;
        run = (m.mode == 1) && (m.t >= h + (n - 1) * st);
        if (sw && m.mode != 2) begin
            r.mode = 2;
            r.s = 0;
        end else if (m.mode == 0) begin
            if (lk) begin
                r.mode = 1;
                r.t = 0;
            end
        end else if (m.mode == 1) begin
            drop = !lk;
            if (run && FILT) drop = !lk && (m.z == 3);
            if (drop) begin
                r.mode = 0;
                if (run) r.lost = 1'b1;
            end else if (m.t < 1000000) begin
                r.t = m.t + 1;
            end
        end else begin
            if (m.s >= swc - 1) begin
                if (!sw) begin
                    r.mode = lk ? 1 : 0;
                    r.t = 0;
                end
            end else begin
                r.s = m.s + 1;
            end
        end
        r.z = (run && !lk) ? ((m.z < 3) ? m.z + 1 : 3) : 0;
        return r;
    endfunction

    // Channel i is released once HOLD + i*STAGGER edges have passed since start.
    function automatic logic [15:0] exp_ro(mdl_t m, int n, int h, int st);
        logic [15:0] v;
        v = '1;
        if (m.mode == 1)
            for (int i = 0; i < n; i++)
                if (m.t >= h + i * st) v[i] = 1'b0;
        return v;
    endfunction

    function automatic logic exp_rdy(mdl_t m, int n, int h, int st);
        return (m.mode == 1) && (m.t >= h + (n - 1) * st);
    endfunction

    task automatic drive(int n, bit rn, bit pll, bit sw);
        exp_t e;
        logic [15:0] v;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst_n = rn;
            pll_locked = pll;
            sw_rst = sw;
            m0 = step(m0, rn, pll, sw, N0, H0, S0, W0);
            m1 = step(m1, rn, pll, sw, N1, H1, S1, W1);
            v = exp_ro(m0, N0, H0, S0);
            e.ro0 = v[N0-1:0];
            e.rdy0 = exp_rdy(m0, N0, H0, S0);
            e.ll0 = m0.lost;
            v = exp_ro(m1, N1, H1, S1);
            e.ro1 = v[N1-1:0];
            e.rdy1 = exp_rdy(m1, N1, H1, S1);
            e.ll1 = m1.lost;
            q.push_back(e);
            armed = 1'b1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (armed) begin
                ntests++;
                if (q.size() == 0) begin
                    nfail++;
                    $display("FAIL sb_empty cyc=%0d got=0 entries want>=1", cyc);
                end else begin
                    e = q.pop_front();
                    if ({ro0, rdy0, ll0} !== {e.ro0, e.rdy0, e.ll0}) begin
                        nfail++;
                        $display("FAIL ch4 cyc=%0d got ro=%b rdy=%b ll=%b want ro=%b rdy=%b ll=%b",
                                 cyc, ro0, rdy0, ll0, e.ro0, e.rdy0, e.ll0);
                    end
                    ntests++;
                    if ({ro1, rdy1, ll1} !== {e.ro1, e.rdy1, e.ll1}) begin
                        nfail++;
                        $display("FAIL ch1 cyc=%0d got ro=%b rdy=%b ll=%b want ro=%b rdy=%b ll=%b",
                                 cyc, ro1, rdy1, ll1, e.ro1, e.rdy1, e.ll1);
                    end
                end
            end
        end
    end

    initial begin : stim
        int plen, slen;
        bit p, s, r;
        m0 = '0;
        m1 = '0;
        drive(3, 0, 0, 0);
        drive(7, 1, 0, 0);
        drive(45, 1, 1, 0);
        drive(5, 1, 0, 0);
        drive(12, 1, 1, 0);
        drive(1, 1, 0, 0);
        drive(50, 1, 1, 0);
        drive(1, 1, 0, 0);
        drive(50, 1, 1, 0);
        drive(2, 1, 0, 0);
        drive(50, 1, 1, 0);
        drive(5, 1, 0, 0);
        drive(50, 1, 1, 0);
        drive(1, 1, 1, 1);
        drive(60, 1, 1, 0);
        drive(20, 1, 1, 1);
        drive(60, 1, 1, 0);
        drive(1, 1, 0, 1);
        drive(3, 1, 0, 0);
        drive(60, 1, 1, 0);
        drive(4, 1, 0, 0);
        drive(22, 1, 1, 0);
        drive(1, 0, 1, 0);
        drive(50, 1, 1, 0);
        plen = 0;
        slen = 0;
        p = 1'b1;
        s = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (plen == 0) begin
                p = ($urandom_range(0, 9) != 0);
                plen = p ? $urandom_range(5, 80) : $urandom_range(1, 6);
            end
            if (slen == 0) begin
                s = ($urandom_range(0, 11) == 0);
                slen = s ? $urandom_range(1, 12) : $urandom_range(10, 90);
            end
            r = ($urandom_range(0, 499) != 0);
            drive(1, r, p, s);
            plen--;
            slen--;
        end
        @(posedge clk);
        #2;
        ntests++;
        if (q.size() != 0) begin
            nfail++;
            $display("FAIL sb_drain got=%0d entries want=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
